// File: rtl/argmax_reader.sv
// rtl/argmax_reader.sv - scans an output-layer SRAM and reports the index and value of the largest signed word
module argmax_reader #(
  parameter int DATA_W      = 16,
  parameter int NUM_CLASSES = 10,
  parameter int ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] class_out,
  output logic [DATA_W-1:0] max_val
);

  if ((2 ** ADDR_W) < NUM_CLASSES) begin : g_addr_w_check
    $error("argmax_reader: ADDR_W too small for NUM_CLASSES");
  end

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0]  class_q, class_d;
  logic [DATA_W-1:0]  max_q, max_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      class_q   <= '0;
      max_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      class_q   <= class_d;
      max_q     <= max_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_READ;
          rd_addr_d = '0;
        end
      end
      S_READ: begin
        if (rd_addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // valid_q/idx_q trail the read strobe by one edge, matching the SRAM's registered data.
  always_comb begin
    valid_d = (state_q == S_READ);
    idx_d   = rd_addr_q;
    class_d = class_q;
    max_d   = max_q;
    if (valid_q) begin
      if ((idx_q == '0) || ($signed(rd_data) > $signed(max_q))) begin
        class_d = idx_q;
        max_d   = rd_data;
      end
    end
  end

  assign rd_en     = (state_q == S_READ);
  assign rd_addr   = rd_addr_q;
  assign busy      = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign class_out = class_q;
  assign max_val   = max_q;

endmodule

// File: tb/tb_argmax_reader.sv
// tb/tb_argmax_reader.sv - directed vector bench for argmax_reader with a registered-read SRAM model
module tb_argmax_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;
  logic [3:0]  class_out;
  logic [15:0] max_val;

  logic [15:0] mem [0:15];

  int nvec;
  int nerr;

  typedef struct {
    logic [9:0][15:0] w;
    int               cls;
    logic [15:0]      mx;
  } vec_t;

  vec_t tbl [8];

  argmax_reader #(.DATA_W(16), .NUM_CLASSES(10), .ADDR_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .class_out (class_out),
    .max_val   (max_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3, input int a4,
                              input int a5, input int a6, input int a7, input int a8, input int a9,
                              input int cls, input int mx);
    vec_t v;
    v.w[0] = 16'(a0); v.w[1] = 16'(a1); v.w[2] = 16'(a2); v.w[3] = 16'(a3); v.w[4] = 16'(a4);
    v.w[5] = 16'(a5); v.w[6] = 16'(a6); v.w[7] = 16'(a7); v.w[8] = 16'(a8); v.w[9] = 16'(a9);
    v.cls  = cls;
    v.mx   = 16'(mx);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic load_mem(input vec_t v);
    for (int i = 0; i < 16; i++) mem[i] = (i < 10) ? v.w[i] : 16'h0;
  endtask

  // One scan from a start pulse; extra_start re-pulses start at edges 3 and 11.
  task automatic run_and_check(input string nm, input int exp_cls, input logic [15:0] exp_max,
                               input bit extra_start);
    bit seq_ok;
    bit quiet_ok;
    seq_ok = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      if (!(rd_en === 1'b1 && rd_addr === 4'(k) && busy === 1'b1 && done === 1'b0)) seq_ok = 1'b0;
      if (extra_start && k == 2) start = 1'b1;
      if (extra_start && k == 3) start = 1'b0;
    end
    chk({nm, " addr_seq"}, 32'(seq_ok), 32'd1);
    @(negedge clk);
    chk({nm, " drain"}, {29'd0, rd_en, busy, done}, 32'b010);
    if (extra_start) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, " done_cycle"}, {29'd0, rd_en, busy, done}, 32'b001);
    chk({nm, " class"}, 32'(class_out), 32'(exp_cls));
    chk({nm, " max"}, 32'(max_val), 32'(exp_max));
    @(negedge clk);
    chk({nm, " post_done"}, {29'd0, rd_en, busy, done}, 32'b000);
    chk({nm, " hold"}, {12'd0, class_out, max_val}, {12'd0, 4'(exp_cls), exp_max});
    if (extra_start) begin
      quiet_ok = 1'b1;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk);
        if (done !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) quiet_ok = 1'b0;
      end
      chk({nm, " no_queued_run"}, 32'(quiet_ok), 32'd1);
    end
  endtask

  initial begin
    int done_cnt;
    int done_at [4];
    int cls_at [4];
    bit quiet_ok;
    bit got_done;

    nvec    = 0;
    nerr    = 0;
    reset   = 1'b1;
    start   = 1'b0;
    rd_data = 16'h0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;

    tbl[0] = mk(3, -5, 12, 7, 0, -1, 12, 2, 9, 4, 2, 12);
    tbl[1] = mk(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, 0, 16'h8000);
    tbl[2] = mk(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32767, 9, 16'h8001);
    tbl[3] = mk(-100, -3, -50, -20, -9, -60, -4, -30, -80, -7, 1, 16'hFFFD);
    tbl[4] = mk(0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9);
    tbl[5] = mk(-1, -1, -1, -1, 32767, -1, -1, -1, -1, -1, 4, 16'h7FFF);
    tbl[6] = mk(5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 0, 5);
    tbl[7] = mk(9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0, 9);

    #1;
    chk("reset_state", {5'd0, rd_en, rd_addr, busy, done, class_out, max_val},
        {5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'd0});
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      load_mem(tbl[v]);
      run_and_check($sformatf("vec%0d", v), tbl[v].cls, tbl[v].mx, 1'b0);
    end

    load_mem(tbl[0]);
    run_and_check("restart_ignored", 2, 16'd12, 1'b1);

    // Asynchronous abort between edges 5 and 6.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset", {5'd0, rd_en, rd_addr, busy, done, class_out, max_val},
        {5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'd0});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    quiet_ok = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) quiet_ok = 1'b0;
    end
    chk("abort_no_done", 32'(quiet_ok), 32'd1);
    run_and_check("after_reset", 2, 16'd12, 1'b0);

    // start held high: accepts at edges 0, 13, 26.
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      done_at[i] = -1;
      cls_at[i]  = -1;
    end
    @(negedge clk) start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (done_cnt < 4) begin
          done_at[done_cnt] = c;
          cls_at[done_cnt]  = int'(class_out);
        end
        done_cnt++;
      end
    end
    start = 1'b0;
    chk("held_done_count", 32'(done_cnt), 32'd2);
    chk("held_first_done", 32'(done_at[0]), 32'd11);
    chk("held_spacing", 32'(done_at[1] - done_at[0]), 32'd13);
    chk("held_class0", 32'(cls_at[0]), 32'd2);
    chk("held_class1", 32'(cls_at[1]), 32'd2);
    got_done = 1'b0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got_done = 1'b1;
        chk("held_third_class", 32'(class_out), 32'd2);
      end
    end
    chk("held_third_done", 32'(got_done), 32'd1);
    @(negedge clk);
    chk("held_idle", {30'd0, busy, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
